// File: rtl/pipe_result_receiver.sv
// -----------------------------------------------------------------------------
// pipe_result_receiver
//
// Collects results from a fixed-latency producing pipeline into a small FIFO
// and hands out issue credits so the pipeline is never asked for more results
// than the FIFO can absorb.
//
// Every issue is tracked by an LAT-bit shift register. When the oldest bit is
// set, the matching result is on res_i and is captured into the FIFO tail.
// A credit is granted when buffered results plus results still in flight leave
// room in the FIFO. A pop in the same cycle is not counted as extra room.
// err_o is a sticky flag. It is set when an issue arrives without a credit,
// or when a result reaches a full FIFO that is not popping in the same cycle.
// In the second case the result is dropped. Only reset clears err_o.
//
// Optional feature: define RESULT_COUNT_EN to enable the 16-bit popped-result
// counter on total_o. Without it total_o is tied to zero.
//
// Ports
//   clk       in   single clock, rising-edge active
//   rst       in   asynchronous active-low reset
//   issue_i   in   upstream issued an operand pair this cycle
//   credit_o  out  issue permitted this cycle
//   res_i     in   pipeline result bus (DWIDTH)
//   data_o    out  FIFO head result, 0 when empty (DWIDTH)
//   valid_o   out  data_o holds a result
//   ready_i   in   downstream accepts data_o
//   count_o   out  FIFO occupancy ($clog2(DEPTH+1))
//   err_o     out  sticky protocol error
//   total_o   out  popped-result counter (16)
// -----------------------------------------------------------------------------
module pipe_result_receiver #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,   // power of two, >= 2
  parameter int LAT    = 2    // >= 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_i,
  output logic                       credit_o,
  input  logic [DWIDTH-1:0]          res_i,
  output logic [DWIDTH-1:0]          data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       err_o,
  output logic [15:0]                total_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [LAT-1:0]    sr_q, sr_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] mem [DEPTH];

  logic capture, pop, push, full, drop;

  assign capture = sr_q[LAT-1];
  assign full    = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign pop     = valid_o & ready_i;
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  // A pop in this cycle is not counted as extra room. The credit depends only
  // on registered state, so upstream does not see a path from ready_i.
  assign credit_o = (int'(count_q) + $countones(sr_q)) < DEPTH;

  assign data_o  = valid_o ? mem[rptr_q] : '0;
  assign count_o = count_q;
  assign err_o   = err_q;

  // NOTE: next-state logic lives in always_comb with a default assignment for
  // every output first. This keeps the block purely combinational, so no latch
  // is inferred on any path that skips an assignment.
  always_comb begin
    sr_d    = (sr_q << 1) | LAT'(issue_i);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    err_d   = err_q | (issue_i & ~credit_o) | drop;

    // Pointers are AW bits wide with DEPTH a power of two, so they wrap
    // naturally modulo DEPTH.
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the storage array has no reset. Entries are only visible through
  // count_q, and data_o is forced to 0 when the FIFO is empty, so stale
  // contents can never leak out. This also lets the array map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= res_i;
  end

`ifdef RESULT_COUNT_EN
  logic [15:0] total_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     total_q <= '0;
    else if (pop) total_q <= total_q + 16'd1;   // wraps 0xFFFF -> 0x0000
  end

  assign total_o = total_q;
`else
  assign total_o = '0;
`endif

endmodule

// File: tb/tb_pipe_result_receiver.sv
// -----------------------------------------------------------------------------
// tb_pipe_result_receiver
//
// Randomized and directed stimulus for pipe_result_receiver (DWIDTH=8,
// DEPTH=4, LAT=2). The reference model is transaction-level. Each issue
// becomes a scheduled capture cycle (issue cycle + LAT) in a queue, and
// buffered results live in a plain queue. Credit is computed as
// buffered + scheduled < DEPTH. Outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_result_receiver;

  localparam int DWIDTH = 8;
  localparam int DEPTH  = 4;
  localparam int LAT    = 2;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              issue_i = 1'b0;
  logic              credit_o;
  logic [DWIDTH-1:0] res_i = '0;
  logic [DWIDTH-1:0] data_o;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic [CW-1:0]     count_o;
  logic              err_o;
  logic [15:0]       total_o;

  pipe_result_receiver #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .issue_i  (issue_i),
    .credit_o (credit_o),
    .res_i    (res_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .count_o  (count_o),
    .err_o    (err_o),
    .total_o  (total_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int unsigned       cyc = 0;
  logic [DWIDTH-1:0] fifo_m [$];
  int unsigned       pend_m [$];   // absolute cycles at which captures occur
  bit                err_m  = 1'b0;
  int unsigned       pops_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic bit model_credit();
    return (fifo_m.size() + pend_m.size()) < DEPTH;
  endfunction

  task automatic check_outputs();
    logic [31:0] exp_total;
`ifdef RESULT_COUNT_EN
    exp_total = pops_m & 32'hFFFF;
`else
    exp_total = 0;
`endif
    check("credit", credit_o, model_credit());
    check("valid",  valid_o,  fifo_m.size() != 0);
    check("data",   data_o,   fifo_m.size() != 0 ? fifo_m[0] : '0);
    check("count",  count_o,  fifo_m.size());
    check("err",    err_o,    err_m);
    check("total",  total_o,  exp_total);
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_step();
    bit pop, cap, cred;
    cred = model_credit();
    pop  = (fifo_m.size() != 0) && ready_i;
    cap  = (pend_m.size() != 0) && (pend_m[0] == cyc);
    if (pop) begin
      void'(fifo_m.pop_front());
      pops_m++;
    end
    if (cap) begin
      void'(pend_m.pop_front());
      if (fifo_m.size() < DEPTH) fifo_m.push_back(res_i);
      else err_m = 1'b1;
    end
    if (issue_i) begin
      if (!cred) err_m = 1'b1;
      pend_m.push_back(cyc + LAT);
    end
    cyc++;
  endtask

  task automatic cycle(input bit iss, input bit rdy, input logic [DWIDTH-1:0] res);
    @(negedge clk);
    check_outputs();
    issue_i = iss;
    ready_i = rdy;
    res_i   = res;
    model_step();
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    issue_i = 1'b0;
    ready_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_valid",  valid_o,  1'b0);
    check("rst_count",  count_o,  '0);
    check("rst_credit", credit_o, 1'b1);
    check("rst_data",   data_o,   '0);
    check("rst_err",    err_o,    1'b0);
    check("rst_total",  total_o,  '0);
    fifo_m.delete();
    pend_m.delete();
    err_m  = 1'b0;
    pops_m = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    model_step();
    @(posedge clk);
  endtask

  initial begin
    do_reset();

    // Legal random traffic: only issue when the model grants a credit.
    for (int i = 0; i < 300; i++)
      cycle(model_credit() && ($urandom_range(1, 0) == 1),
            $urandom_range(2, 0) != 0, DWIDTH'($urandom));

    // Drain to idle.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, DWIDTH'($urandom));

    // Single issue, result 0x5A two cycles later, consumed immediately.
    cycle(1'b1, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h5A);
    #1;
    check("single_valid", valid_o, 1'b1);
    check("single_data",  data_o,  8'h5A);
    cycle(1'b0, 1'b1, 8'h00);
    #1;
    check("single_empty", count_o, '0);

    // Four back-to-back issues with downstream stalled.
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 8'h10 + 8'(k));
    #1;
    check("b2b_credit", credit_o, 1'b0);
    check("b2b_err",    err_o,    1'b0);
    for (int k = 4; k < 6; k++) cycle(1'b0, 1'b0, 8'h10 + 8'(k));
    #1;
    check("b2b_full", count_o, 3'd4);
    for (int k = 0; k < 4; k++) begin
      #1 check("b2b_order", data_o, 8'h12 + 8'(k));
      cycle(1'b0, 1'b1, 8'h00);
    end

    // Fill, then issue without credit: the 0xDD result is dropped.
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 8'h20 + 8'(k));
    cycle(1'b0, 1'b0, 8'h24);
    cycle(1'b0, 1'b0, 8'h25);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    #1 check("ovf_err", err_o, 1'b1);
    cycle(1'b0, 1'b0, 8'hDD);
    // Another excess issue whose capture coincides with a pop: 0xEE goes last.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'hEE);
    #1 check("pushpop_count", count_o, 3'd4);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 8'h00);
    #1 check("pushpop_last", data_o, 8'hEE);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);

    // Reset with two results in flight and three buffered.
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 8'h30 + 8'(k));
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 8'h77);

    // Unconstrained random traffic, including credit violations and drops.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(1, 0) == 1, $urandom_range(3, 0) != 0, DWIDTH'($urandom));

    @(negedge clk);
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
